// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding, load-use stall and a tracker for one outstanding multiply.
// Define FWD_MUL_EN to build the multiply tracker and the multiplier forwarding path (Fwd=3).
module fwd_hazard_unit #(
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2,
    parameter int MUL_LAT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     IdValid,
    input  logic [NUM_SRC*REG_W-1:0] IdSrc,
    input  logic [NUM_SRC-1:0]       IdSrcUse,
    input  logic                     IdWb,
    input  logic [REG_W-1:0]         IdRd,
    input  logic                     IdIsMul,
    input  logic [NUM_SRC*REG_W-1:0] IdExSrc,
    input  logic                     IdExWb,
    input  logic [REG_W-1:0]         IdExRd,
    input  logic                     IdExIsLoad,
    input  logic                     ExMemWb,
    input  logic [REG_W-1:0]         ExMemRd,
    input  logic                     MemWbWb,
    input  logic [REG_W-1:0]         MemWbRd,
    output logic [NUM_SRC*2-1:0]     Fwd,
    output logic                     Stall,
    output logic                     MulBusy,
    output logic                     MulDone,
    output logic [REG_W-1:0]         MulRdOut
);
    localparam int CNT_W = $clog2(MUL_LAT + 1);

    logic             load_hit;
    logic             load_use;
    logic             mul_stall;
    logic             mul_fwd_v;
    logic [REG_W-1:0] mul_rd_d;

    always_comb begin
        load_hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (IdSrcUse[k] && (IdExRd == IdSrc[k*REG_W +: REG_W])) load_hit = 1'b1;
        end
    end

    assign load_use = IdValid & IdExIsLoad & IdExWb & (IdExRd != '0) & load_hit;
    assign Stall    = ~rst & (load_use | mul_stall);

    // EX/MEM beats the multiplier result, which beats MEM/WB; r0 never forwards
    always_comb begin
        Fwd = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (rst)
                Fwd[2*k +: 2] = 2'd0;
            else if (ExMemWb && (ExMemRd != '0) && (ExMemRd == IdExSrc[k*REG_W +: REG_W]))
                Fwd[2*k +: 2] = 2'd2;
            else if (mul_fwd_v && (mul_rd_d != '0) && (mul_rd_d == IdExSrc[k*REG_W +: REG_W]))
                Fwd[2*k +: 2] = 2'd3;
            else if (MemWbWb && (MemWbRd != '0) && (MemWbRd == IdExSrc[k*REG_W +: REG_W]))
                Fwd[2*k +: 2] = 2'd1;
        end
    end

`ifdef FWD_MUL_EN
    // state | meaning
    // IDLE  | no multiply outstanding
    // BUSY  | multiply in flight, cnt cycles until its result is written
    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [REG_W-1:0] mul_rd, mul_rd_next;
    logic             mul_done;
    logic             issue;
    logic             raw_hit;

    assign mul_done = (state == BUSY) && (cnt == CNT_W'(1));
    assign issue    = IdValid & IdIsMul & ~Stall;

    always_comb begin
        raw_hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (IdSrcUse[k] && (mul_rd != '0) && (IdSrc[k*REG_W +: REG_W] == mul_rd)) raw_hit = 1'b1;
        end
    end

    // The completing cycle releases all hazards so a dependent or a new multiply can leave ID
    assign mul_stall = (state == BUSY) & ~mul_done & IdValid &
                       (raw_hit | (IdWb & (IdRd == mul_rd)) | IdIsMul);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mul_rd    <= '0;
            mul_rd_d  <= '0;
            mul_fwd_v <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            mul_rd    <= mul_rd_next;
            mul_fwd_v <= mul_done;
            if (mul_done) mul_rd_d <= mul_rd;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        mul_rd_next = mul_rd;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_next  = BUSY;
                    cnt_next    = CNT_W'(MUL_LAT);
                    mul_rd_next = IdRd;
                end
            end
            BUSY: begin
                cnt_next = cnt - CNT_W'(1);
                if (mul_done) begin
                    if (issue) begin
                        cnt_next    = CNT_W'(MUL_LAT);
                        mul_rd_next = IdRd;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign MulBusy  = (state == BUSY);
    assign MulDone  = mul_done;
    assign MulRdOut = mul_rd;
`else
    logic unused_mul_in;

    assign unused_mul_in = ^{clk, IdWb, IdRd, IdIsMul};
    assign mul_stall     = 1'b0;
    assign mul_fwd_v     = 1'b0;
    assign mul_rd_d      = '0;
    assign MulBusy       = 1'b0;
    assign MulDone       = 1'b0;
    assign MulRdOut      = '0;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed vector table, multiply corner sequences, randomized run vs model.
// Multiply-specific expectations follow FWD_MUL_EN, matching however the design is built.
module tb_fwd_hazard_unit;
    localparam int REG_W   = 5;
    localparam int NUM_SRC = 2;
    localparam int MUL_LAT = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     IdValid;
    logic [NUM_SRC*REG_W-1:0] IdSrc;
    logic [NUM_SRC-1:0]       IdSrcUse;
    logic                     IdWb;
    logic [REG_W-1:0]         IdRd;
    logic                     IdIsMul;
    logic [NUM_SRC*REG_W-1:0] IdExSrc;
    logic                     IdExWb;
    logic [REG_W-1:0]         IdExRd;
    logic                     IdExIsLoad;
    logic                     ExMemWb;
    logic [REG_W-1:0]         ExMemRd;
    logic                     MemWbWb;
    logic [REG_W-1:0]         MemWbRd;
    logic [NUM_SRC*2-1:0]     Fwd;
    logic                     Stall;
    logic                     MulBusy;
    logic                     MulDone;
    logic [REG_W-1:0]         MulRdOut;

    fwd_hazard_unit #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .IdValid(IdValid), .IdSrc(IdSrc), .IdSrcUse(IdSrcUse),
        .IdWb(IdWb), .IdRd(IdRd), .IdIsMul(IdIsMul), .IdExSrc(IdExSrc), .IdExWb(IdExWb),
        .IdExRd(IdExRd), .IdExIsLoad(IdExIsLoad), .ExMemWb(ExMemWb), .ExMemRd(ExMemRd),
        .MemWbWb(MemWbWb), .MemWbRd(MemWbRd), .Fwd(Fwd), .Stall(Stall), .MulBusy(MulBusy),
        .MulDone(MulDone), .MulRdOut(MulRdOut)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a multiply issued in cycle t completes in cycle t+MUL_LAT,
    // and its result is forwardable in the single cycle after that.
    bit         m_active;
    int         m_done_cyc;
    logic [4:0] m_rd;
    int         m_fv_cyc;
    logic [4:0] m_fv_rd;

    typedef struct {
        logic       id_valid;
        logic [9:0] id_src;
        logic [1:0] id_src_use;
        logic [9:0] id_ex_src;
        logic       id_ex_wb;
        logic       id_ex_load;
        logic [4:0] id_ex_rd;
        logic       ex_mem_wb;
        logic [4:0] ex_mem_rd;
        logic       mem_wb_wb;
        logic [4:0] mem_wb_rd;
        logic [3:0] e_fwd;
        logic       e_stall;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic clear_inputs();
        IdValid = 0; IdSrc = '0; IdSrcUse = '0; IdWb = 0; IdRd = '0; IdIsMul = 0;
        IdExSrc = '0; IdExWb = 0; IdExRd = '0; IdExIsLoad = 0;
        ExMemWb = 0; ExMemRd = '0; MemWbWb = 0; MemWbRd = '0;
    endtask

    task automatic model_reset();
        m_active = 0; m_done_cyc = -1; m_rd = '0; m_fv_cyc = -1; m_fv_rd = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        model_reset();
    endtask

    function automatic bit m_busy();
        return m_active && (cyc <= m_done_cyc);
    endfunction

    function automatic bit m_done();
        return m_active && (cyc == m_done_cyc);
    endfunction

    function automatic logic [3:0] ref_fwd();
        logic [3:0] f;
        logic [4:0] s;
        f = '0;
        if (rst) return f;
        for (int k = 0; k < NUM_SRC; k++) begin
            s = IdExSrc[k*REG_W +: REG_W];
            if (ExMemWb && ExMemRd != 0 && ExMemRd == s) f[2*k +: 2] = 2'd2;
            else if (m_fv_cyc == cyc && m_fv_rd != 0 && m_fv_rd == s) f[2*k +: 2] = 2'd3;
            else if (MemWbWb && MemWbRd != 0 && MemWbRd == s) f[2*k +: 2] = 2'd1;
        end
        return f;
    endfunction

    function automatic logic ref_stall();
        bit lu, raw, ms;
        logic [4:0] s;
        lu = 0; raw = 0;
        if (rst || !IdValid) return 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            s = IdSrc[k*REG_W +: REG_W];
            if (IdSrcUse[k]) begin
                if (IdExIsLoad && IdExWb && IdExRd != 0 && IdExRd == s) lu = 1;
                if (m_rd != 0 && s == m_rd) raw = 1;
            end
        end
        ms = m_busy() && !m_done() && (raw || (IdWb && IdRd == m_rd) || IdIsMul);
        return lu || ms;
    endfunction

    initial begin
        rst = 1;
        clear_inputs();
        model_reset();

        // outputs forced quiet while rst is high, even with matching inputs
        ExMemWb = 1; ExMemRd = 5'd5; IdExSrc = {5'd5, 5'd5};
        IdValid = 1; IdExIsLoad = 1; IdExWb = 1; IdExRd = 5'd7; IdSrc = {5'd7, 5'd7}; IdSrcUse = 2'b11;
        #1;
        chk("rst_fwd", 32'(Fwd), 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        do_reset();
        chk("reset_busy", 32'(MulBusy), 32'd0);
        chk("reset_done", 32'(MulDone), 32'd0);
        chk("reset_rdout", 32'(MulRdOut), 32'd0);
        chk("reset_fwd", 32'(Fwd), 32'd0);
        chk("reset_stall", 32'(Stall), 32'd0);

        vecs[0]  = '{1, {5'd0, 5'd0}, 2'b00, {5'd3, 5'd5}, 0, 0, 5'd0, 1, 5'd5, 1, 5'd5, 4'b0010, 0};
        vecs[1]  = '{1, {5'd0, 5'd0}, 2'b00, {5'd3, 5'd5}, 0, 0, 5'd0, 0, 5'd5, 1, 5'd5, 4'b0001, 0};
        vecs[2]  = '{1, {5'd0, 5'd0}, 2'b00, {5'd0, 5'd0}, 0, 0, 5'd0, 1, 5'd0, 1, 5'd0, 4'b0000, 0};
        vecs[3]  = '{1, {5'd7, 5'd2}, 2'b10, {5'd0, 5'd0}, 1, 1, 5'd7, 0, 5'd0, 0, 5'd0, 4'b0000, 1};
        vecs[4]  = '{1, {5'd7, 5'd2}, 2'b01, {5'd0, 5'd0}, 1, 1, 5'd7, 0, 5'd0, 0, 5'd0, 4'b0000, 0};
        vecs[5]  = '{0, {5'd7, 5'd2}, 2'b10, {5'd0, 5'd0}, 1, 1, 5'd7, 0, 5'd0, 0, 5'd0, 4'b0000, 0};
        vecs[6]  = '{1, {5'd0, 5'd0}, 2'b11, {5'd0, 5'd0}, 1, 1, 5'd0, 0, 5'd0, 0, 5'd0, 4'b0000, 0};
        vecs[7]  = '{1, {5'd0, 5'd0}, 2'b00, {5'd3, 5'd4}, 0, 0, 5'd0, 1, 5'd3, 1, 5'd4, 4'b1001, 0};
        vecs[8]  = '{1, {5'd0, 5'd0}, 2'b00, {5'd3, 5'd3}, 0, 0, 5'd0, 0, 5'd3, 0, 5'd3, 4'b0000, 0};
        vecs[9]  = '{1, {5'd7, 5'd7}, 2'b01, {5'd0, 5'd0}, 0, 1, 5'd7, 0, 5'd0, 0, 5'd0, 4'b0000, 0};
        vecs[10] = '{1, {5'd6, 5'd7}, 2'b11, {5'd6, 5'd6}, 1, 1, 5'd6, 1, 5'd6, 0, 5'd0, 4'b1010, 1};

        foreach (vecs[i]) begin
            clear_inputs();
            IdValid = vecs[i].id_valid; IdSrc = vecs[i].id_src; IdSrcUse = vecs[i].id_src_use;
            IdExSrc = vecs[i].id_ex_src; IdExWb = vecs[i].id_ex_wb; IdExIsLoad = vecs[i].id_ex_load;
            IdExRd = vecs[i].id_ex_rd; ExMemWb = vecs[i].ex_mem_wb; ExMemRd = vecs[i].ex_mem_rd;
            MemWbWb = vecs[i].mem_wb_wb; MemWbRd = vecs[i].mem_wb_rd;
            #1;
            chk($sformatf("vec%0d_fwd", i), 32'(Fwd), 32'(vecs[i].e_fwd));
            chk($sformatf("vec%0d_stall", i), 32'(Stall), 32'(vecs[i].e_stall));
            #1;
        end

`ifdef FWD_MUL_EN
        // mul r9 then a dependent on r9
        do_reset();
        IdValid = 1; IdIsMul = 1; IdWb = 1; IdRd = 5'd9; #1;
        chk("mul_issue_stall", 32'(Stall), 32'd0);
        tick();
        IdIsMul = 0; IdRd = 5'd10; IdSrc = {5'd1, 5'd9}; IdSrcUse = 2'b01;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk($sformatf("dep_stall_t%0d", c), 32'(Stall), 32'd1);
            chk($sformatf("dep_busy_t%0d", c), 32'(MulBusy), 32'd1);
            chk($sformatf("dep_nodone_t%0d", c), 32'(MulDone), 32'd0);
            chk($sformatf("dep_rdout_t%0d", c), 32'(MulRdOut), 32'd9);
            tick();
        end
        #1;
        chk("dep_done_t4", 32'(MulDone), 32'd1);
        chk("dep_release_t4", 32'(Stall), 32'd0);
        tick();
        clear_inputs(); IdExSrc = {5'd1, 5'd9}; MemWbWb = 1; MemWbRd = 5'd9; #1;
        chk("dep_fwd3_t5", 32'(Fwd), 32'b0011);
        chk("dep_idle_t5", 32'(MulBusy), 32'd0);
        tick(); #1;
        chk("fwd3_one_cycle", 32'(Fwd), 32'b0001);

        // back-to-back multiplies
        do_reset();
        IdValid = 1; IdIsMul = 1; IdWb = 1; IdRd = 5'd9;
        tick();
        IdRd = 5'd12;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk($sformatf("b2b_hold_t%0d", c), 32'(Stall), 32'd1);
            tick();
        end
        #1;
        chk("b2b_done_t4", 32'(MulDone), 32'd1);
        chk("b2b_issue_t4", 32'(Stall), 32'd0);
        tick();
        clear_inputs(); #1;
        chk("b2b_busy_t5", 32'(MulBusy), 32'd1);
        chk("b2b_rdout_t5", 32'(MulRdOut), 32'd12);
        chk("b2b_nodone_t5", 32'(MulDone), 32'd0);
        for (int c = 0; c < 3; c++) tick();
        #1;
        chk("b2b_second_done", 32'(MulDone), 32'd1);

        // reset in the middle of a multiply
        do_reset();
        IdValid = 1; IdIsMul = 1; IdWb = 1; IdRd = 5'd9;
        tick();
        clear_inputs();
        tick();
        rst = 1;
        tick();
        rst = 0;
        IdValid = 1; IdSrc = {5'd9, 5'd9}; IdSrcUse = 2'b11; IdExSrc = {5'd9, 5'd9}; #1;
        chk("rstmid_busy", 32'(MulBusy), 32'd0);
        chk("rstmid_stall", 32'(Stall), 32'd0);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("rstmid_nodone_%0d", c), 32'(MulDone), 32'd0);
            chk($sformatf("rstmid_nofwd3_%0d", c), 32'(Fwd), 32'd0);
            tick();
        end
`else
        // multiply input has no effect when the tracker is not built
        do_reset();
        IdValid = 1; IdIsMul = 1; IdWb = 1; IdRd = 5'd9;
        tick();
        IdIsMul = 0; IdSrc = {5'd9, 5'd9}; IdSrcUse = 2'b11; IdExSrc = {5'd9, 5'd9};
        for (int c = 1; c <= 6; c++) begin
            #1;
            chk($sformatf("nomul_stall_%0d", c), 32'(Stall), 32'd0);
            chk($sformatf("nomul_busy_%0d", c), 32'(MulBusy), 32'd0);
            chk($sformatf("nomul_done_%0d", c), 32'(MulDone), 32'd0);
            chk($sformatf("nomul_rdout_%0d", c), 32'(MulRdOut), 32'd0);
            chk($sformatf("nomul_fwd_%0d", c), 32'(Fwd), 32'd0);
            tick();
        end
`endif

        // randomized run against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            bit issue;
            bit e_done;
            logic e_stall;
            rst        = ($urandom_range(0, 59) == 0);
            IdValid    = ($urandom_range(0, 9) != 0);
            IdSrc      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            IdSrcUse   = 2'($urandom_range(0, 3));
            IdWb       = 1'($urandom_range(0, 1));
            IdRd       = 5'($urandom_range(0, 7));
            IdIsMul    = ($urandom_range(0, 3) == 0);
            IdExSrc    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            IdExWb     = 1'($urandom_range(0, 1));
            IdExRd     = 5'($urandom_range(0, 7));
            IdExIsLoad = 1'($urandom_range(0, 1));
            ExMemWb    = 1'($urandom_range(0, 1));
            ExMemRd    = 5'($urandom_range(0, 7));
            MemWbWb    = 1'($urandom_range(0, 1));
            MemWbRd    = 5'($urandom_range(0, 7));
            #1;
            e_stall = ref_stall();
            e_done  = m_done();
            chk("rnd_fwd", 32'(Fwd), 32'(ref_fwd()));
            chk("rnd_stall", 32'(Stall), 32'(e_stall));
            chk("rnd_busy", 32'(MulBusy), 32'(m_busy()));
            chk("rnd_done", 32'(MulDone), 32'(e_done));
            chk("rnd_rdout", 32'(MulRdOut), 32'(m_rd));
`ifdef FWD_MUL_EN
            issue = IdValid && IdIsMul && !e_stall && !rst;
`else
            issue = 0;
`endif
            if (e_done) begin
                m_fv_cyc = cyc + 1;
                m_fv_rd  = m_rd;
            end
            if (issue) begin
                m_active   = 1;
                m_done_cyc = cyc + MUL_LAT;
                m_rd       = IdRd;
            end
            if (rst) model_reset();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the pipelined MIPS core, generalising EX-stage forwarding to NUM_SRC operand ports. Adds load-use stall generation and a registered tracker for one outstanding multi-cycle multiply. It sits beside the ID/EX pipeline registers:
- drives the EX operand muxes (Fwd);
- drives the PC / IF-ID hold and ID/EX bubble (Stall).

## Interface
Parameters:
- REG_W, 5, register index width
- NUM_SRC, 2, operand ports per instruction (1..4)
- MUL_LAT, 4, multiply latency in cycles from EX entry to result (>= 2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- IdValid  in  1  ID holds a real instruction
- IdSrc  in  NUM_SRC*REG_W  ID source indices, port k at [k*REG_W +: REG_W]
- IdSrcUse  in  NUM_SRC  port k actually read by the ID instruction
- IdWb, IdRd  in  1, REG_W  ID instruction writes IdRd
- IdIsMul  in  1  ID instruction is a multi-cycle multiply
- IdExSrc  in  NUM_SRC*REG_W  sources of the instruction in EX
- IdExWb, IdExRd, IdExIsLoad  in  1, REG_W, 1  EX-stage destination info
- ExMemWb, ExMemRd  in  1, REG_W  EX/MEM writer
- MemWbWb, MemWbRd  in  1, REG_W  MEM/WB writer
- Fwd  out  NUM_SRC*2  per-port select: 0 regfile, 1 MEM/WB, 2 EX/MEM, 3 multiplier result
- Stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- MulBusy  out  1  multiply outstanding
- MulDone  out  1  one-cycle pulse; multiplier result written to regfile at this edge
- MulRdOut  out  REG_W  destination of outstanding/just-completed multiply

## Operation
Forwarding (combinational, per port k, priority order):
- ExMemWb & ExMemRd!=0 & ExMemRd==src gives 2.
- Else MulFwdV & MulRdD==src gives 3 (only with FWD_MUL_EN).
- Else MemWbWb & MemWbRd!=0 & MemWbRd==src gives 1.
- Else 0.
- MEM/WB match is evaluated independently of whether EX/MEM writes. Register 0 never forwards.

Load-use stall:
- Asserted when IdValid & IdExIsLoad & IdExWb & IdExRd!=0 & (IdExRd equals IdSrc[k] for any k with IdSrcUse[k]).

Multiply tracker FSM, states IDLE and BUSY:
- Issue = IdValid & IdIsMul & ~Stall.
- IDLE, on issue: go BUSY, MulRd<=IdRd, Cnt<=MUL_LAT.
- BUSY: Cnt decrements each cycle. MulDone = BUSY & Cnt==1.
- At MulDone: return to IDLE, unless a new multiply issues the same cycle, in which case stay BUSY and reload MulRd/Cnt.
- At MulDone edge: MulFwdV<=1 and MulRdD<=MulRd; otherwise MulFwdV<=0. MulFwdV is valid for exactly one cycle.
- MulRdOut = MulRd.

Multiply stall while BUSY & ~MulDone & IdValid, for any of:
- RAW: a used IdSrc equals MulRd and MulRd!=0.
- WAW: IdWb & IdRd==MulRd.
- Structural: IdIsMul.

Combined stall:
- Stall = load-use | multiply stall.
- Stall is 0 whenever IdValid=0.

## Timing
- Fwd and Stall are combinational, same cycle as their inputs.
- MulBusy, MulDone, MulRdOut and MulFwdV are registered or derived from registers.
- Multiply issued from ID at cycle t: MulBusy=1 from t+1, MulDone=1 at t+MUL_LAT.
- A dependent in ID during t+MUL_LAT is released. It enters EX at t+MUL_LAT+1 with Fwd=3 on the matching port.
- Reset values: state IDLE, Cnt=0, MulRd=0, MulRdD=0, MulFwdV=0, so MulBusy=0, MulDone=0, MulRdOut=0.
- Fwd=0 and Stall=0 apply under rst for the same-cycle inputs only.
- rst mid-multiply abandons the operation: no MulDone and no Fwd=3.
- Load-use and multiply stall may coincide; Stall is their OR, and Cnt still decrements.

## Configuration
- FWD_MUL_EN defined: multiply tracker, Fwd=3, MulBusy/MulDone/MulRdOut behave as above.
- FWD_MUL_EN undefined:
  - No tracker state.
  - IdIsMul is ignored.
  - MulBusy=MulDone=0 and MulRdOut=0.
  - Fwd never 3; Stall is load-use only.

## Test plan
- EX/MEM and MEM/WB both write r5, IdExSrc port0=r5 -> Fwd[1:0]=2. Drop ExMemWb -> Fwd[1:0]=1 (MEM/WB checked independently).
- ExMemWb=1, ExMemRd=0, IdExSrc=r0 on all ports -> every Fwd field 0.
- Load to r7 in EX, ID uses r7 on port1 with IdSrcUse[1]=1 -> Stall=1 for one cycle. Same case with IdSrcUse[1]=0 -> Stall=0.
- FWD_MUL_EN, MUL_LAT=4, mul r9 issued at t0, dependent on r9 in ID:
  - Stall=1 during t0+1..t0+3.
  - MulDone=1 at t0+4.
  - Fwd=3 at t0+5.
- Back-to-back muls: second held until MulDone, issues in the MulDone cycle. MulBusy stays 1 and MulRdOut updates to the new destination.
- rst at t0+2 of an outstanding mul -> next cycle MulBusy=0, no MulDone pulse, Stall=0 for dependents.
